// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR serial pattern generator.
// The default tap masks all keep bit 0 set so a nonzero state never collapses to zero.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam logic [3:0]  TAPS_W4  = 4'b1011;
    localparam logic [7:0]  TAPS_W8  = 8'h1D;
    localparam logic [15:0] TAPS_W16 = 16'h002D;
    localparam logic [31:0] TAPS_W32 = 32'h0000_00C5;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/lfsr_serial_gen_core.sv
// LFSR state register: seed load, Fibonacci scramble step, and zero-filling serial shift.
// The sequencing FSM outside decides which of the three actions happens on each clock.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] TAPS     = TAPS_W4,
    parameter logic [WIDTH-1:0] ZERO_SUB = {{(WIDTH-1){1'b0}}, 1'b1}
)(
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_step,
    input  logic             i_shift,
    output logic [WIDTH-1:0] o_state
);

    logic [WIDTH-1:0] r_lfsr;
    logic             w_fb;

    assign w_fb    = ^(r_lfsr & TAPS);
    assign o_state = r_lfsr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_lfsr <= ZERO_SUB;
        end else if (i_load) begin
            r_lfsr <= i_load_val;
        end else if (i_step) begin
            r_lfsr <= {w_fb, r_lfsr[WIDTH-1:1]};
        end else if (i_shift) begin
            r_lfsr <= {1'b0, r_lfsr[WIDTH-1:1]};
        end
    end

    // Without a tap on bit 0 the register can shift itself down to all zeros.
    always_ff @(posedge clock) begin
        assert (TAPS[0] == 1'b1)
            else $error("lfsr_core: TAPS[0] must be set");
        assert (ZERO_SUB != '0)
            else $error("lfsr_core: ZERO_SUB must be nonzero");
    end

endmodule

// File: rtl/lfsr_serial_gen.sv
// Seeded LFSR scrambler that streams its final state LSB-first over valid/ready.
// A start is taken only while idle; busy covers scramble plus stream, done pulses once at the end.
module lfsr_serial_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] TAPS     = TAPS_W4,
    parameter int               CNT_W    = 8,
    parameter logic [WIDTH-1:0] ZERO_SUB = {{(WIDTH-1){1'b0}}, 1'b1}
)(
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] run_len,
    output logic             out_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam int               BIT_W    = clog2(WIDTH + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_run_len;
    logic [CNT_W-1:0] r_step_cnt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic             w_step;
    logic             w_shift;
    logic [CNT_W-1:0] w_step_nxt;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_lfsr;

    assign w_accept   = (r_state == IDLE) && start;
    assign w_step     = (r_state == RUN);
    assign w_shift    = (r_state == SHIFT) && out_ready;
    assign w_load_val = (seed == '0) ? ZERO_SUB : seed;
    // RUN is only entered with run_len >= 1 and left when this equals it, so it never wraps.
    assign w_step_nxt = r_step_cnt + CNT_W'(1);

    lfsr_core #(
        .WIDTH    (WIDTH),
        .TAPS     (TAPS),
        .ZERO_SUB (ZERO_SUB)
    ) u_core (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_accept),
        .i_load_val (w_load_val),
        .i_step     (w_step),
        .i_shift    (w_shift),
        .o_state    (w_lfsr)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_run_len   <= '0;
            r_step_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_run_len  <= run_len;
                        r_step_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_busy     <= 1'b1;
                        if (run_len == '0) begin
                            r_state     <= SHIFT;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_step_cnt <= w_step_nxt;
                    if (w_step_nxt == r_run_len) begin
                        r_state     <= SHIFT;
                        r_out_valid <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (out_ready) begin
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state     <= IDLE;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out_bit   = w_lfsr[0];
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_lfsr_serial_gen.sv
// Bench for lfsr_serial_gen: a 4-bit default instance and an 8-bit instance checked each cycle
// against a transaction-level model, plus directed scenarios with hand-computed expectations.
module tb_lfsr_serial_gen;

    logic       clock;
    logic       rst_n;

    logic       start4, ready4, out_bit4, out_valid4, busy4, done4;
    logic [3:0] seed4;
    logic [7:0] run4;

    logic       start8, ready8, out_bit8, out_valid8, busy8, done8;
    logic [7:0] seed8;
    logic [7:0] run8;

    int n_vec;
    int n_bad;

    lfsr_serial_gen dut4 (
        .clock     (clock),
        .reset     (rst_n),
        .start     (start4),
        .seed      (seed4),
        .run_len   (run4),
        .out_bit   (out_bit4),
        .out_valid (out_valid4),
        .out_ready (ready4),
        .busy      (busy4),
        .done      (done4)
    );

    lfsr_serial_gen #(
        .WIDTH (8),
        .TAPS  (8'h1D),
        .CNT_W (8)
    ) dut8 (
        .clock     (clock),
        .reset     (rst_n),
        .start     (start8),
        .seed      (seed8),
        .run_len   (run8),
        .out_bit   (out_bit8),
        .out_valid (out_valid8),
        .out_ready (ready8),
        .busy      (busy8),
        .done      (done8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference software LFSR: n Fibonacci steps on a w-bit state.
    function automatic logic [31:0] lfsr_steps(input logic [31:0] s0, input int n,
                                               input int w, input logic [31:0] taps);
        logic [31:0] s;
        int          fb;
        s = s0 & ((32'h1 << w) - 32'h1);
        for (int i = 0; i < n; i++) begin
            fb = $countones(s & taps) % 2;
            s  = (s >> 1) | (32'(fb) << (w - 1));
        end
        return s;
    endfunction

    function automatic logic f_start(input int d);   return (d != 0) ? start8 : start4; endfunction
    function automatic logic f_ready(input int d);   return (d != 0) ? ready8 : ready4; endfunction
    function automatic logic [31:0] f_seed(input int d);
        return (d != 0) ? {24'h0, seed8} : {28'h0, seed4};
    endfunction
    function automatic int f_run(input int d);       return (d != 0) ? int'(run8) : int'(run4); endfunction
    function automatic int f_width(input int d);     return (d != 0) ? 8 : 4; endfunction
    function automatic logic [31:0] f_taps(input int d); return (d != 0) ? 32'h1D : 32'hB; endfunction
    function automatic logic a_busy(input int d);    return (d != 0) ? busy8 : busy4; endfunction
    function automatic logic a_done(input int d);    return (d != 0) ? done8 : done4; endfunction
    function automatic logic a_valid(input int d);   return (d != 0) ? out_valid8 : out_valid4; endfunction
    function automatic logic a_bit(input int d);     return (d != 0) ? out_bit8 : out_bit4; endfunction

    // Transaction model: a job is the scrambled word plus a countdown to first valid and a bit index.
    bit          m_busy[2];
    bit          m_done[2];
    bit          m_fresh[2];
    int          m_wait[2];
    int          m_k[2];
    logic [31:0] m_final[2];

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_busy[d]  <= 1'b0;
                m_done[d]  <= 1'b0;
                m_fresh[d] <= 1'b1;
                m_wait[d]  <= 0;
                m_k[d]     <= 0;
                m_final[d] <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_done[d] <= 1'b0;
                if (!m_busy[d]) begin
                    if (f_start(d)) begin
                        m_busy[d]  <= 1'b1;
                        m_fresh[d] <= 1'b0;
                        m_wait[d]  <= f_run(d);
                        m_k[d]     <= 0;
                        m_final[d] <= lfsr_steps((f_seed(d) == 0) ? 32'h1 : f_seed(d),
                                                 f_run(d), f_width(d), f_taps(d));
                    end
                end else if (m_wait[d] > 0) begin
                    m_wait[d] <= m_wait[d] - 1;
                end else if (f_ready(d)) begin
                    m_k[d] <= m_k[d] + 1;
                    if (m_k[d] == f_width(d) - 1) begin
                        m_busy[d] <= 1'b0;
                        m_done[d] <= 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d_busy", f_width(d)), 32'(a_busy(d)), 32'(m_busy[d]));
            chk($sformatf("dut%0d_done", f_width(d)), 32'(a_done(d)), 32'(m_done[d]));
            chk($sformatf("dut%0d_valid", f_width(d)), 32'(a_valid(d)),
                32'(m_busy[d] && m_wait[d] == 0));
            if (m_busy[d] && m_wait[d] == 0) begin
                chk($sformatf("dut%0d_bit%0d", f_width(d), m_k[d]), 32'(a_bit(d)),
                    32'(m_final[d][m_k[d]]));
            end else if (m_fresh[d]) begin
                chk($sformatf("dut%0d_bit_rst", f_width(d)), 32'(a_bit(d)), 32'h1);
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic pulse4(input logic [3:0] sd, input logic [7:0] rl);
        seed4  = sd;
        run4   = rl;
        start4 = 1'b1;
        cyc();
        start4 = 1'b0;
    endtask

    task automatic wait_valid4(output int lat);
        lat = 1;
        while (!out_valid4 && lat < 300) begin
            cyc();
            lat++;
        end
    endtask

    task automatic collect4(output logic [3:0] got);
        ready4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            got[i] = out_bit4;
            cyc();
        end
    endtask

    task automatic directed4(input logic [3:0] sd, input logic [7:0] rl, input int exp_lat,
                             input logic [3:0] exp_bits, input string tag);
        int         lat;
        logic [3:0] got;
        ready4 = 1'b1;
        pulse4(sd, rl);
        wait_valid4(lat);
        chk({tag, "_lat"}, lat, exp_lat);
        collect4(got);
        chk({tag, "_stream"}, {28'h0, got}, {28'h0, exp_bits});
        chk({tag, "_done"}, 32'(done4), 32'h1);
        chk({tag, "_busy_low"}, 32'(busy4), 32'h0);
        cyc();
        chk({tag, "_done_1cyc"}, 32'(done4), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        int         n;
        logic [3:0] got;
        logic [6:0] pat;
        logic [7:0] got8;

        n_vec  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        start4 = 1'b0; ready4 = 1'b0; seed4 = '0; run4 = '0;
        start8 = 1'b0; ready8 = 1'b0; seed8 = '0; run8 = '0;

        chk("pin_step1", lfsr_steps(32'h1, 1, 4, 32'hB), 32'h8);
        chk("pin_step2", lfsr_steps(32'h1, 2, 4, 32'hB), 32'hC);
        chk("pin_step3", lfsr_steps(32'h1, 3, 4, 32'hB), 32'hE);
        chk("pin_step4", lfsr_steps(32'h1, 4, 4, 32'hB), 32'h7);
        chk("pin_step8", lfsr_steps(32'h1, 8, 4, 32'hB), 32'hC);
        chk("pin_w8_step2", lfsr_steps(32'h1, 2, 8, 32'h1D), 32'h40);

        cyc(); cyc(); cyc();
        chk("rst_valid", 32'(out_valid4), 32'h0);
        chk("rst_bit", 32'(out_bit4), 32'h1);
        rst_n = 1'b1;
        cyc();

        directed4(4'h1, 8'd8, 9, 4'hC, "s1");
        directed4(4'h0, 8'd0, 1, 4'h1, "s2");

        // Back-pressure: only cycles with ready high move the stream.
        pulse4(4'hE, 8'd0);
        pat = 7'b1011001;
        n   = 0;
        got = '0;
        for (int i = 0; i < 7; i++) begin
            ready4 = pat[i];
            chk("s3_no_early_done", 32'(done4), 32'h0);
            if (ready4 && out_valid4 && n < 4) begin
                got[n] = out_bit4;
                n++;
            end
            cyc();
        end
        chk("s3_count", n, 4);
        chk("s3_stream", {28'h0, got}, 32'hE);
        chk("s3_done", 32'(done4), 32'h1);
        cyc();

        // Start while busy is ignored; start in the done cycle is taken.
        ready4 = 1'b1;
        pulse4(4'h1, 8'd8);
        cyc(); cyc();
        pulse4(4'h5, 8'd0);
        seed4 = 4'h9;
        run4  = 8'd3;
        wait_valid4(lat);
        collect4(got);
        chk("s4_stream", {28'h0, got}, 32'hC);
        chk("s4_done", 32'(done4), 32'h1);
        pulse4(4'hE, 8'd0);
        chk("s4_restart_busy", 32'(busy4), 32'h1);
        for (int i = 0; i < 6; i++) cyc();

        // Reset in the middle of the serial stream.
        pulse4(4'h1, 8'd8);
        wait_valid4(lat);
        cyc(); cyc();
        rst_n = 1'b0;
        #1;
        chk("s5_valid", 32'(out_valid4), 32'h0);
        chk("s5_busy", 32'(busy4), 32'h0);
        chk("s5_done", 32'(done4), 32'h0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("s5_no_done", 32'(done4), 32'h0);
        directed4(4'h1, 8'd8, 9, 4'hC, "s5_rerun");

        // Full-range step count on the 8-bit instance.
        ready8 = 1'b1;
        seed8  = 8'h01;
        run8   = 8'd255;
        start8 = 1'b1;
        cyc();
        start8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 400) begin
            cyc();
            lat++;
        end
        chk("s6_lat", lat, 256);
        for (int i = 0; i < 8; i++) begin
            got8[i] = out_bit8;
            cyc();
        end
        chk("s6_stream", {24'h0, got8}, lfsr_steps(32'h1, 255, 8, 32'h1D));
        chk("s6_done", 32'(done8), 32'h1);
        cyc();

        // Random traffic on both instances.
        for (int c = 0; c < 1500; c++) begin
            start4 = ($urandom % 4) == 0;
            seed4  = 4'($urandom);
            if (($urandom % 5) == 0) seed4 = '0;
            run4   = 8'($urandom_range(0, 11));
            ready4 = ($urandom % 3) != 0;
            start8 = ($urandom % 4) == 0;
            seed8  = 8'($urandom);
            if (($urandom % 6) == 0) seed8 = '0;
            run8   = (($urandom % 40) == 0) ? 8'd255 : 8'($urandom_range(0, 15));
            ready8 = ($urandom % 3) != 0;
            if (($urandom % 250) == 0) begin
                rst_n = 1'b0;
                cyc();
                rst_n = 1'b1;
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
